// File: rtl/m_muldiv_seq_if.sv
// Request/response bundle of the sequential multiply/divide unit.
// The master side issues requests and consumes results; the unit is the slave.
interface m_muldiv_seq_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_result, out_tag, busy
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, flush, out_ready,
    output in_ready, out_valid, out_result, out_tag, busy
  );
endinterface

// File: rtl/m_muldiv_seq.sv
// RISC-V M-extension unit: single-cycle multiply, restoring divide (one quotient
// bit per cycle). Divide-by-zero and signed overflow take the short multiply path.
module m_muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic          clk,
  input  logic          resetn,
  m_muldiv_seq_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

  state_e           state, state_nxt;
  op_e              op_q;
  logic [XLEN-1:0]  a_q, b_q;
  logic [TAG_W-1:0] tag_q;
  logic [XLEN:0]    rem_q;
  logic [XLEN-1:0]  dvd_q, dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  result_q;
  logic [TAG_W-1:0] out_tag_q;

  // Request decode, evaluated on the raw inputs so the route is chosen at accept.
  logic            accept, in_signed_div, in_b_zero, in_ovf, in_slow;
  logic [XLEN-1:0] a_mag, b_mag;

  assign accept        = bus.in_valid && bus.in_ready;
  assign in_signed_div = bus.in_op[2] && !bus.in_op[0];
  assign in_b_zero     = (bus.in_b == '0);
  assign in_ovf        = in_signed_div && (bus.in_a == {1'b1, {(XLEN-1){1'b0}}})
                         && (bus.in_b == '1);
  assign in_slow       = bus.in_op[2] && !in_b_zero && !in_ovf;
  assign a_mag = (in_signed_div && bus.in_a[XLEN-1]) ? -bus.in_a : bus.in_a;
  assign b_mag = (in_signed_div && bus.in_b[XLEN-1]) ? -bus.in_b : bus.in_b;

  // Multiplier: both operands widened by one bit so every variant is a signed multiply.
  logic                   a_sx, b_sx;
  logic signed [XLEN:0]   a_ext, b_ext;
  logic [2*XLEN-1:0]      prod;

  assign a_sx  = (op_q inside {OP_MUL, OP_MULH, OP_MULHSU}) && a_q[XLEN-1];
  assign b_sx  = (op_q inside {OP_MUL, OP_MULH}) && b_q[XLEN-1];
  assign a_ext = $signed({a_sx, a_q});
  assign b_ext = $signed({b_sx, b_q});
  assign prod  = (2*XLEN)'((2*XLEN)'(a_ext) * (2*XLEN)'(b_ext));

  // Restoring divide step: subtract divisor from the partial remainder shifted left.
  logic [XLEN+1:0] trial;
  logic            q_bit;

  assign trial = {rem_q, dvd_q[XLEN-1]} - {2'b00, dvs_q};
  assign q_bit = !trial[XLEN+1];

  logic [XLEN-1:0] mul_result, fix_result;

  always_comb begin
    mul_result = '0;
    unique case (op_q)
      OP_MUL:                        mul_result = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  mul_result = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               mul_result = (b_q == '0) ? '1 : a_q;
      OP_REM, OP_REMU:               mul_result = (b_q == '0) ? a_q : '0;
      default:                       mul_result = '0;
    endcase
  end

  always_comb begin
    fix_result = '0;
    if (op_q inside {OP_DIV, OP_DIVU})
      fix_result = (op_q == OP_DIV && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -dvd_q : dvd_q;
    else
      fix_result = (op_q == OP_REM && a_q[XLEN-1]) ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order simulators evaluate processes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a variable unassigned and a latch is never inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (accept) state_nxt = in_slow ? S_DIV : S_MUL;
      S_MUL:  state_nxt = S_DONE;
      S_DIV:  if (cnt_q == CNT_W'(XLEN-1)) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: if (bus.out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (bus.flush) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q      <= OP_MUL;
      a_q       <= '0;
      b_q       <= '0;
      tag_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      out_tag_q <= '0;
    end else begin
      if (accept) begin
        op_q  <= op_e'(bus.in_op);
        a_q   <= bus.in_a;
        b_q   <= bus.in_b;
        tag_q <= bus.in_tag;
        rem_q <= '0;
        dvd_q <= a_mag;
        dvs_q <= b_mag;
        cnt_q <= '0;
      end
      if (state == S_DIV) begin
        rem_q <= q_bit ? trial[XLEN:0] : {rem_q[XLEN-1:0], dvd_q[XLEN-1]};
        dvd_q <= {dvd_q[XLEN-2:0], q_bit};
        cnt_q <= cnt_q + CNT_W'(1);
      end
      // A flushed operation must not disturb the visible result registers.
      if (!bus.flush && state == S_MUL) begin
        result_q  <= mul_result;
        out_tag_q <= tag_q;
      end
      if (!bus.flush && state == S_FIX) begin
        result_q  <= fix_result;
        out_tag_q <= tag_q;
      end
    end
  end

  assign bus.in_ready   = (state == S_IDLE) && !bus.flush;
  assign bus.busy       = (state != S_IDLE);
  assign bus.out_valid  = (state == S_DONE);
  assign bus.out_result = result_q;
  assign bus.out_tag    = out_tag_q;
endmodule

// File: doc/m_muldiv_seq.md
M_MULDIV_SEQ -- requirements
Module: m_muldiv_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (8..64, even).
REQ-002 SHALL have parameter TAG_W, default 5, width of the pass-through destination tag.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request.
REQ-007 SHALL have port in_op  input  3  RISC-V funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 SHALL have ports in_a, in_b  input  XLEN  rs1, rs2 operands.
REQ-009 SHALL have port in_tag  input  TAG_W  tag returned with result.
REQ-010 SHALL have port flush  input  1  abort the operation in flight.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have ports out_result  output  XLEN, out_tag  output  TAG_W.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, MUL, DIV, FIX, DONE; in_ready = (state==IDLE) && !flush.
REQ-016 Accept edge: in_valid && in_ready; SHALL latch op, tag, operands; inputs ignored in all other cycles.
REQ-017 MUL ops: IDLE->MUL on accept; MUL->DONE next edge; one (XLEN+1)x(XLEN+1) signed product with per-op sign/zero extension (MULHSU: a signed, b unsigned).
REQ-018 MUL result = product[XLEN-1:0]; MULH/MULHSU/MULHU = product[2*XLEN-1:XLEN].
REQ-019 Divide ops SHALL use restoring division on magnitudes, one quotient bit per cycle: IDLE->DIV on accept, XLEN steps, DIV->FIX after step XLEN, FIX->DONE next edge.
REQ-020 Each DIV step: trial = {rem,next dividend bit} - divisor; if trial non-negative rem=trial, quotient bit 1, else quotient bit 0.
REQ-021 FIX SHALL negate quotient if signs of a and b differ (DIV) and negate remainder if a negative (REM); unsigned ops unchanged.
REQ-022 Divide-by-zero (b==0): SHALL bypass DIV, go to MUL-latency path (DONE one edge after accept); DIV/DIVU result all-ones, REM/REMU result = a.
REQ-023 Signed overflow (a==most-negative, b==all-ones, DIV/REM): SHALL take the same 1-edge path; DIV result = a, REM result = 0.
REQ-024 Latency (accept edge to out_valid rising): MUL ops and special cases 1 edge; regular divide XLEN+1 edges.
REQ-025 out_valid = (state==DONE); out_result/out_tag SHALL be stable while out_valid && !out_ready.
REQ-026 DONE->IDLE on out_valid && out_ready; a new request is accepted no earlier than the following edge.
REQ-027 flush high at an edge SHALL force IDLE from any state, drop the result, deassert out_valid next cycle; flush with in_valid in IDLE accepts nothing.
REQ-028 out_result/out_tag SHALL hold the last value when out_valid is low (no X propagation).

Reset
REQ-029 resetn low SHALL immediately force state IDLE, out_valid 0, busy 0, out_result 0, out_tag 0, step counter 0, regardless of clk; in_ready 1 after release (flush low).
REQ-030 Reset mid-operation SHALL discard the operation; no out_valid after release until a new accept.

Verification (XLEN=32)
REQ-031 MULH a=0xFFFFFFFF b=0xFFFFFFFF -> 0x00000000; MULHU same -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF b=0xFFFFFFFF -> 0xFFFFFFFF; MUL -> 0x00000001; each 1 edge.
REQ-032 DIV a=0xFFFFFFF9(-7) b=2 -> 0xFFFFFFFD, out_valid exactly 33 edges after accept; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
REQ-033 DIVU a=0x1234 b=0 -> 0xFFFFFFFF, REM a=0x1234 b=0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; all 1 edge.
REQ-034 out_ready held low 5 cycles after DIV result: out_valid, out_result, out_tag stable, in_ready low; release -> IDLE next edge.
REQ-035 flush pulsed 10 cycles into DIV: out_valid never asserts, in_ready high next cycle, subsequent MUL 3*5 -> 15 with correct tag.
REQ-036 resetn low 15 cycles into DIV, asynchronous to clk: outputs 0 immediately; after release no stale out_valid.
